// File: rtl/multi_flash_module.sv
// Multi-channel LED flasher: a shared millisecond prescaler times CH LEDs, each set to OFF/ON/BLINK/ONESHOT.
// Optional macro FLASH_SYNC_EN adds Sync_In, which realigns the prescaler and all channel counters.
module multi_flash_module #(
  parameter int CH_W       = 2,
  parameter int TICK_DIV   = 50_000,
  parameter int PER_W      = 12,
  parameter int DEF_PERIOD = 1000
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Cfg_Wr,
  input  logic [CH_W-1:0]      Cfg_Ch,
  input  logic [1:0]           Cfg_Mode,
  input  logic [PER_W-1:0]     Cfg_Period,
`ifdef FLASH_SYNC_EN
  input  logic                 Sync_In,
`endif
  output logic [2**CH_W-1:0]   LED_Out,
  output logic                 Tick_Out
);

  localparam int CH   = 2**CH_W;
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PER_W-1:0] DEF_PER = PER_W'(DEF_PERIOD);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic              sync;
  logic [PS_W-1:0]   prescaler;
  logic [PS_W-1:0]   prescaler_nxt;
  mode_e             cfg_mode;
  mode_e             mode_q   [CH];
  logic [PER_W-1:0]  period_q [CH];
  logic [PER_W-1:0]  cnt_q    [CH];
  logic [CH-1:0]     led_q;
  logic [CH-1:0]     wr_hit;
  logic [CH-1:0]     terminal;

`ifdef FLASH_SYNC_EN
  assign sync = Sync_In;
`else
  assign sync = 1'b0;
`endif

  assign cfg_mode = mode_e'(Cfg_Mode);
  assign LED_Out  = led_q;

  // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prescaler_nxt = prescaler + 1'b1;
    if (sync || prescaler == PS_LAST) prescaler_nxt = '0;
  end

  // Tick_Out is registered from the next prescaler value so it is high exactly while prescaler == TICK_DIV-1.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      prescaler <= '0;
      Tick_Out  <= 1'b0;
    end else begin
      prescaler <= prescaler_nxt;
      Tick_Out  <= (prescaler_nxt == PS_LAST);
    end
  end

  // A period of 0 behaves as 1, so terminal is cnt == 0; this form avoids any subtraction wrap.
  always_comb begin
    wr_hit   = '0;
    terminal = '0;
    for (int c = 0; c < CH; c++) begin
      wr_hit[c]   = Cfg_Wr && (Cfg_Ch == CH_W'(c));
      terminal[c] = (period_q[c] == '0) ? (cnt_q[c] == '0)
                                         : (cnt_q[c] == period_q[c] - 1'b1);
    end
  end

  // NOTE: the per-channel arrays are small register files, so every entry is reset explicitly.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      led_q <= '0;
      for (int c = 0; c < CH; c++) begin
        mode_q[c]   <= MODE_BLINK;
        period_q[c] <= DEF_PER;
        cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (wr_hit[c]) begin
          // A write beats a coincident tick or sync on its own channel.
          mode_q[c]   <= cfg_mode;
          period_q[c] <= Cfg_Period;
          cnt_q[c]    <= '0;
          led_q[c]    <= (cfg_mode == MODE_ON) || (cfg_mode == MODE_ONESHOT);
        end else if (sync) begin
          cnt_q[c] <= '0;
          if (mode_q[c] == MODE_BLINK) led_q[c] <= 1'b0;
        end else if (Tick_Out) begin
          unique case (mode_q[c])
            MODE_OFF: begin
              cnt_q[c] <= '0;
              led_q[c] <= 1'b0;
            end
            MODE_ON: begin
              cnt_q[c] <= '0;
              led_q[c] <= 1'b1;
            end
            MODE_BLINK: begin
              if (terminal[c]) begin
                cnt_q[c] <= '0;
                led_q[c] <= ~led_q[c];
              end else begin
                cnt_q[c] <= cnt_q[c] + 1'b1;
              end
            end
            MODE_ONESHOT: begin
              if (terminal[c]) begin
                cnt_q[c]  <= '0;
                led_q[c]  <= 1'b0;
                mode_q[c] <= MODE_OFF;
              end else begin
                cnt_q[c] <= cnt_q[c] + 1'b1;
              end
            end
            default: cnt_q[c] <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_flash_module.sv
// Self-checking bench for multi_flash_module: directed scenarios plus random writes against a tick-count model.
module tb_multi_flash_module;

  localparam int CH_W  = 2;
  localparam int CH    = 4;
  localparam int TD    = 4;
  localparam int PER_W = 4;
  localparam int DEFP  = 3;

  logic             CLK = 1'b0;
  logic             RST_n = 1'b0;
  logic             Cfg_Wr = 1'b0;
  logic [CH_W-1:0]  Cfg_Ch = '0;
  logic [1:0]       Cfg_Mode = '0;
  logic [PER_W-1:0] Cfg_Period = '0;
  logic             Sync_In = 1'b0;
  logic [CH-1:0]    LED_Out;
  logic             Tick_Out;

  int vectors = 0;
  int miscompares = 0;

  // Model: each channel remembers its mode, effective period and ticks elapsed since its last write/sync.
  int m_mode    [CH];
  int m_eff     [CH];
  int m_elapsed [CH];
  int m_ps;
  bit m_tick;

  multi_flash_module #(
    .CH_W(CH_W), .TICK_DIV(TD), .PER_W(PER_W), .DEF_PERIOD(DEFP)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .Cfg_Wr     (Cfg_Wr),
    .Cfg_Ch     (Cfg_Ch),
    .Cfg_Mode   (Cfg_Mode),
    .Cfg_Period (Cfg_Period),
`ifdef FLASH_SYNC_EN
    .Sync_In    (Sync_In),
`endif
    .LED_Out    (LED_Out),
    .Tick_Out   (Tick_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mode[c]    = 2;
      m_eff[c]     = DEFP;
      m_elapsed[c] = 0;
    end
    m_ps   = 0;
    m_tick = 1'b0;
  endtask

  function automatic logic [CH-1:0] exp_leds();
    logic [CH-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      case (m_mode[c])
        1:       v[c] = 1'b1;
        2:       v[c] = ((m_elapsed[c] / m_eff[c]) % 2) == 1;
        3:       v[c] = 1'b1;
        default: v[c] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input bit wr, input int ch, input int mode, input int per, input bit sync);
    bit t;
    t = m_tick;
    for (int c = 0; c < CH; c++) begin
      if (wr && ch == c) begin
        m_mode[c]    = mode;
        m_eff[c]     = (per == 0) ? 1 : per;
        m_elapsed[c] = 0;
      end else if (sync) begin
        m_elapsed[c] = 0;
      end else if (t) begin
        m_elapsed[c]++;
        if (m_mode[c] == 3 && m_elapsed[c] >= m_eff[c]) m_mode[c] = 0;
      end
    end
    m_ps   = sync ? 0 : (m_ps + 1) % TD;
    m_tick = (m_ps == TD - 1);
  endtask

  task automatic step(input bit wr = 0, input int ch = 0, input int mode = 0, input int per = 0,
                      input bit sync = 0, input string tag = "step");
    Cfg_Wr     = wr;
    Cfg_Ch     = CH_W'(ch);
    Cfg_Mode   = 2'(mode);
    Cfg_Period = PER_W'(per);
    Sync_In    = sync;
    @(posedge CLK);
    model_edge(wr, ch, mode, per, sync);
    @(negedge CLK);
    Cfg_Wr  = 1'b0;
    Sync_In = 1'b0;
    check({tag, ".led"}, 32'(LED_Out), 32'(exp_leds()));
    check({tag, ".tick"}, 32'(Tick_Out), 32'(m_tick));
  endtask

  task automatic free_run_after_reset(input string tag);
    for (int i = 1; i <= 50; i++) begin
      step(0, 0, 0, 0, 0, tag);
      if (i == 12) check({tag, ".rise12"}, 32'(LED_Out), 32'hF);
      if (i == 48) check({tag, ".low48"}, 32'(LED_Out), 32'h0);
    end
  endtask

  initial begin
    bit found;
    model_reset();
    RST_n = 1'b0;
    #12;
    check("reset.led", 32'(LED_Out), 32'h0);
    check("reset.tick", 32'(Tick_Out), 32'h0);
    @(negedge CLK);
    RST_n = 1'b1;
    free_run_after_reset("boot");

    // ch1 ON, ch2 OFF, ch3 ONESHOT period 2
    step(1, 1, 1, 0, 0, "wr_ch1_on");
    step(1, 2, 0, 0, 0, "wr_ch2_off");
    step(1, 3, 3, 2, 0, "wr_ch3_one");
    check("wr_101", 32'(LED_Out[3:1]), 32'b101);
    repeat (24) step(0, 0, 0, 0, 0, "oneshot_run");
    check("ch3_stays_off", 32'(LED_Out[3]), 32'h0);

    // ch0 BLINK with period 0 toggles every tick
    step(1, 0, 2, 0, 0, "wr_ch0_p0");
    repeat (16) step(0, 0, 0, 0, 0, "p0_run");

    // write ch2 BLINK period 5 on the same edge as ch2's terminal tick
    step(1, 2, 2, 3, 0, "wr_ch2_blink3");
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_tick && ((m_elapsed[2] + 1) % m_eff[2] == 0)) found = 1'b1;
      else step(0, 0, 0, 0, 0, "seek_term");
    end
    check("term_found", 32'(found), 32'h1);
    step(1, 2, 2, 5, 0, "wr_on_term");
    check("term_led", 32'(LED_Out[2]), 32'h0);
    repeat (48) step(0, 0, 0, 0, 0, "term_run");

    // random configuration traffic
    repeat (300) begin
      if ($urandom_range(3) == 0)
        step(1, int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(15)), 0, "rnd_wr");
      else
        step(0, 0, 0, 0, 0, "rnd_run");
    end

    // asynchronous reset between edges while a tick is pending
    step(1, 1, 1, 0, 0, "pre_rst_on");
    for (int k = 0; k < 2 * TD && !m_tick; k++) step(0, 0, 0, 0, 0, "seek_tick");
    check("pre_rst_tick", 32'(Tick_Out), 32'h1);
    #2;
    RST_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.led", 32'(LED_Out), 32'h0);
    check("async_rst.tick", 32'(Tick_Out), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    free_run_after_reset("reboot");

`ifdef FLASH_SYNC_EN
    step(1, 0, 2, 2, 0, "s_ch0");
    repeat (5) step(0, 0, 0, 0, 0, "s_run");
    step(1, 1, 2, 3, 0, "s_ch1");
    repeat (3) step(0, 0, 0, 0, 0, "s_run");
    step(1, 2, 1, 0, 0, "s_ch2_on");
    step(1, 3, 2, 1, 0, "s_ch3");
    repeat (7) step(0, 0, 0, 0, 0, "s_run");
    step(0, 0, 0, 0, 1, "sync");
    check("sync_blink_low", 32'(LED_Out & 4'b1011), 32'h0);
    check("sync_on_kept", 32'(LED_Out[2]), 32'h1);
    repeat (40) step(0, 0, 0, 0, 0, "sync_run");
    step(1, 1, 2, 2, 1, "sync_with_wr");
    repeat (20) step(0, 0, 0, 0, 0, "sync_wr_run");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
